// File: rtl/gfx_pkg.sv
// Shared Q8.8 fixed-point types and constants for the geometry pipeline.
package gfx_pkg;

  localparam int FXP_FRAC = 8;

  typedef logic signed [15:0] fxp16_t;
  typedef fxp16_t [15:0] mat4_t;

  localparam fxp16_t FXP_ONE = 16'sh0100;
  localparam fxp16_t FXP_MAX = 16'sh7FFF;
  localparam fxp16_t FXP_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_DONE = 2'd2
  } vt_state_t;

endpackage

// File: rtl/vt_row_mac.sv
// One matrix row dotted with (x, y, z, 1), rounded half-up and narrowed to Q8.8.
// Out-of-range results clamp when VERTEX_TRANSFORM_SAT_EN is defined, otherwise wrap.
module vt_row_mac
  import gfx_pkg::*;
(
  input  logic signed [15:0] m0,
  input  logic signed [15:0] m1,
  input  logic signed [15:0] m2,
  input  logic signed [15:0] m3,
  input  logic signed [15:0] x,
  input  logic signed [15:0] y,
  input  logic signed [15:0] z,
  output logic signed [15:0] result,
  output logic               range_err
);

  localparam logic signed [33:0] HALF = 34'sd1 <<< (FXP_FRAC - 1);

  logic signed [33:0] acc;
  logic signed [33:0] rnd;

  // Dot product plus translate, rounding and range check
  always_comb begin
    acc = 34'(m0) * 34'(x) + 34'(m1) * 34'(y) + 34'(m2) * 34'(z)
        + (34'(m3) <<< FXP_FRAC);
    rnd = (acc + HALF) >>> FXP_FRAC;
    range_err = (rnd > 34'sd32767) || (rnd < -34'sd32768);
`ifdef VERTEX_TRANSFORM_SAT_EN
    if (rnd > 34'sd32767) begin
      result = FXP_MAX;
    end else if (rnd < -34'sd32768) begin
      result = FXP_MIN;
    end else begin
      result = rnd[15:0];
    end
`else
    result = rnd[15:0];
`endif
  end

endmodule

// File: rtl/vertex_transform.sv
// Latches a 4x4 Q8.8 model matrix and transforms vertices one matrix row per cycle.
// Build option: VERTEX_TRANSFORM_SAT_EN selects clamping instead of wrapping on overflow.
module vertex_transform
  import gfx_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [255:0]  mat_in,
  input  logic          mat_load,
  output logic          mat_ready,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_x,
  input  logic [15:0]   in_y,
  input  logic [15:0]   in_z,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_x,
  output logic [15:0]   out_y,
  output logic [15:0]   out_z,
  output logic [15:0]   out_w,
  output logic          overflow
);

  vt_state_t state;
  vt_state_t state_next;
  logic [1:0] row_cnt;
  mat4_t      mat;
  fxp16_t     vx;
  fxp16_t     vy;
  fxp16_t     vz;
  logic [3:0] row_base;
  fxp16_t     row_res;
  logic       row_ovf;

  assign mat_ready = (state == ST_IDLE);
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign row_base  = {row_cnt, 2'b00};

  vt_row_mac u_row_mac (
    .m0        (mat[row_base]),
    .m1        (mat[row_base + 4'd1]),
    .m2        (mat[row_base + 4'd2]),
    .m3        (mat[row_base + 4'd3]),
    .x         (vx),
    .y         (vy),
    .z         (vz),
    .result    (row_res),
    .range_err (row_ovf)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_next = ST_ROW;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ROW: begin
        if (row_cnt == 2'd3) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_ROW;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Matrix, vertex, row counter, result registers and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat      <= '0;
      vx       <= 16'sd0;
      vy       <= 16'sd0;
      vz       <= 16'sd0;
      row_cnt  <= 2'd0;
      out_x    <= 16'd0;
      out_y    <= 16'd0;
      out_z    <= 16'd0;
      out_w    <= 16'd0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Loading and accepting together lets the vertex see the new matrix
          if (mat_load) begin
            mat <= mat_in;
          end
          if (in_valid) begin
            vx      <= in_x;
            vy      <= in_y;
            vz      <= in_z;
            row_cnt <= 2'd0;
          end
        end
        ST_ROW: begin
          case (row_cnt)
            2'd0:    out_x <= row_res;
            2'd1:    out_y <= row_res;
            2'd2:    out_z <= row_res;
            default: out_w <= row_res;
          endcase
          overflow <= overflow | row_ovf;
          row_cnt  <= row_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vertex_transform.sv
// Directed scoreboard bench for vertex_transform: expected vectors are queued at acceptance.
module tb_vertex_transform;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [15:0] w;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [255:0]  mat_in;
  logic          mat_load;
  logic          mat_ready;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_x, in_y, in_z;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_x, out_y, out_z, out_w;
  logic          overflow;

  int tests = 0;
  int failures = 0;
  logic signed [15:0] tm [16];
  logic signed [15:0] pm [16];
  vec_t sb [$];
  bit exp_ovf = 1'b0;

  always #5 clk = ~clk;

  vertex_transform dut (
    .clk(clk), .rst_n(rst_n), .mat_in(mat_in), .mat_load(mat_load), .mat_ready(mat_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_z(out_z), .out_w(out_w), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_row(input int r, input logic signed [15:0] x, input logic signed [15:0] y,
                           input logic signed [15:0] z, output logic [15:0] res);
    longint acc, rnd;
    acc = longint'(tm[r*4]) * longint'(x) + longint'(tm[r*4+1]) * longint'(y)
        + longint'(tm[r*4+2]) * longint'(z) + longint'(tm[r*4+3]) * 256;
    rnd = (acc + 128) >>> 8;
    if (rnd > 32767 || rnd < -32768) exp_ovf = 1'b1;
`ifdef VERTEX_TRANSFORM_SAT_EN
    if (rnd > 32767) rnd = 32767;
    if (rnd < -32768) rnd = -32768;
`endif
    res = rnd[15:0];
  endtask

  task automatic set_pm_identity();
    for (int k = 0; k < 16; k++) pm[k] = 16'sd0;
    pm[0] = 16'sh0100; pm[5] = 16'sh0100; pm[10] = 16'sh0100; pm[15] = 16'sh0100;
  endtask

  task automatic clear_pm();
    for (int k = 0; k < 16; k++) pm[k] = 16'sd0;
  endtask

  task automatic apply_pm();
    for (int k = 0; k < 16; k++) mat_in[k*16 +: 16] = pm[k];
  endtask

  // Drive one vertex (optionally loading pm in the same cycle) and queue its expectation.
  task automatic accept(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                        input bit ld, input bit keep, input bit use_c, input vec_t c);
    vec_t e;
    @(negedge clk);
    chk("in_ready_idle", 16'(in_ready), 16'd1);
    in_x = x; in_y = y; in_z = z; in_valid = 1'b1;
    if (ld) begin
      apply_pm();
      mat_load = 1'b1;
      for (int k = 0; k < 16; k++) tm[k] = pm[k];
    end
    if (keep) begin
      model_row(0, x, y, z, e.x);
      model_row(1, x, y, z, e.y);
      model_row(2, x, y, z, e.z);
      model_row(3, x, y, z, e.w);
      sb.push_back(use_c ? c : e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; mat_load = 1'b0;
  endtask

  // Wait for the result, compare against the queue head, hold back-pressure, then handshake.
  task automatic collect(input int hold);
    int n = 0;
    vec_t e;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 16'(n), 16'd4);
    chk("sb_nonempty", 16'(sb.size() != 0), 16'd1);
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    chk("out_x", out_x, e.x);
    chk("out_y", out_y, e.y);
    chk("out_z", out_z, e.z);
    chk("out_w", out_w, e.w);
    chk("overflow", 16'(overflow), 16'(exp_ovf));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      for (int k = 0; k < 16; k++) mat_in[k*16 +: 16] = 16'h1234;
      mat_load = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", 16'(out_valid), 16'd1);
      chk("hold_in_ready", 16'(in_ready), 16'd0);
      chk("hold_mat_ready", 16'(mat_ready), 16'd0);
      chk("hold_out_x", out_x, e.x);
      chk("hold_out_w", out_w, e.w);
    end
    @(negedge clk);
    mat_load = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", 16'(out_valid), 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; mat_in = '0; mat_load = 1'b0; in_valid = 1'b0;
    in_x = 16'd0; in_y = 16'd0; in_z = 16'd0; out_ready = 1'b0;
    for (int k = 0; k < 16; k++) tm[k] = 16'sd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_mat_ready", 16'(mat_ready), 16'd1);
    chk("rst_overflow", 16'(overflow), 16'd0);
    chk("rst_out_x", out_x, 16'd0);
    chk("rst_out_w", out_w, 16'd0);
    @(negedge clk); rst_n = 1'b1;

    // Identity, loaded on its own cycle
    set_pm_identity(); apply_pm();
    @(negedge clk); mat_load = 1'b1; for (int k = 0; k < 16; k++) tm[k] = pm[k];
    @(posedge clk); #1; mat_load = 1'b0;
    accept(16'h0100, 16'h0200, 16'h0300, 1'b0, 1'b1, 1'b1,
           vec_t'({16'h0100, 16'h0200, 16'h0300, 16'h0100}));
    collect(0);

    // Scale plus translate, loaded together with the vertex
    clear_pm(); pm[0] = 16'sh0200; pm[5] = 16'sh0200; pm[10] = 16'sh0200;
    pm[3] = 16'sh0100; pm[15] = 16'sh0100;
    accept(16'h0100, 16'h0100, 16'h0100, 1'b1, 1'b1, 1'b1,
           vec_t'({16'h0300, 16'h0200, 16'h0200, 16'h0100}));
    collect(0);

    // 90 degree rotation about Y
    clear_pm(); pm[2] = 16'sh0100; pm[5] = 16'sh0100; pm[8] = 16'shFF00; pm[15] = 16'sh0100;
    accept(16'h0100, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1,
           vec_t'({16'h0000, 16'h0000, 16'hFF00, 16'h0100}));
    collect(0);

    // Round half up
    clear_pm(); pm[0] = 16'sh0001; pm[15] = 16'sh0100;
    accept(16'h0080, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1,
           vec_t'({16'h0001, 16'h0000, 16'h0000, 16'h0100}));
    collect(0);

    // Overflow: clamp or wrap depending on build, flag sticky afterwards
    clear_pm(); pm[0] = 16'sh7F00; pm[15] = 16'sh0100;
`ifdef VERTEX_TRANSFORM_SAT_EN
    accept(16'h7F00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1,
           vec_t'({16'h7FFF, 16'h0000, 16'h0000, 16'h0100}));
`else
    accept(16'h7F00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1,
           vec_t'({16'h0100, 16'h0000, 16'h0000, 16'h0100}));
`endif
    collect(0);
    chk("ovf_set", 16'(overflow), 16'd1);
    set_pm_identity();
    accept(16'h0500, 16'hFB00, 16'h0080, 1'b1, 1'b1, 1'b0, '0);
    collect(0);
    chk("ovf_sticky", 16'(overflow), 16'd1);

    // Back-pressure with ignored matrix loads, then original matrix still in use
    accept(16'h0010, 16'h0020, 16'h0030, 1'b0, 1'b1, 1'b0, '0);
    collect(10);
    accept(16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b1, 1'b1,
           vec_t'({16'h0100, 16'h0100, 16'h0100, 16'h0100}));
    collect(0);

    // Random matrices and vertices
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 16; k++) pm[k] = 16'($urandom_range(0, 16'hFFFF));
      accept(16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b1, 1'b0, '0);
      collect(i);
    end

    // Reset during ROW 2 discards the vertex and clears the matrix
    set_pm_identity();
    accept(16'h0100, 16'h0200, 16'h0300, 1'b1, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    for (int k = 0; k < 16; k++) tm[k] = 16'sd0;
    exp_ovf = 1'b0;
    #1;
    chk("mid_rst_valid", 16'(out_valid), 16'd0);
    chk("mid_rst_in_ready", 16'(in_ready), 16'd1);
    chk("mid_rst_mat_ready", 16'(mat_ready), 16'd1);
    chk("mid_rst_overflow", 16'(overflow), 16'd0);
    chk("mid_rst_out_x", out_x, 16'd0);
    @(negedge clk); rst_n = 1'b1;
    accept(16'h0300, 16'h0400, 16'h0500, 1'b0, 1'b1, 1'b1, '0);
    collect(0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
